// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_pkg
// Description : Shared types and constants for the register dump transmitter.
//               Holds the FSM state encoding and the UART frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

  // Dump sequencer states. Explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    LOAD      = 3'd2,
    START_BIT = 3'd3,
    DATA      = 3'd4,
    STOP_BIT  = 3'd5
  } state_e;

  // One frame: start bit + 8 data bits + stop bit.
  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = 8;
  // Level of the serial line between frames and during the stop bit.
  localparam logic TXD_IDLE   = 1'b1;

endpackage : reg_dump_pkg
`default_nettype wire

// File: rtl/baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick
// Description : Bit-period timer for the dump transmitter. Counts
//               0..BAUD_DIV-1 and flags the last cycle of each bit period.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i   : system clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the count
//   clear_i : synchronous clear, restarts the bit period at count 0
//   tick_o  : high while the count equals BAUD_DIV-1 (bit boundary)
// ============================================================================
module baud_tick #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;

  // The counter wraps on its own at the bit boundary, so consecutive bits
  // need no help from the sequencer; only the start of a frame clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule : baud_tick
`default_nettype wire

// File: rtl/reg_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_tx
// Description : Debug readback unit for the MiniCPU register bank. On START it
//               reads registers 0..NREG-1 in turn and sends each byte as a
//               UART frame (start bit, 8 data bits LSB first, stop bit).
// Revision    : 1.0 - initial release
//
// Ports
//   CLK    : system clock, all state changes on the rising edge
//   CLR_N  : asynchronous active-low reset, aborts any dump in progress
//   START  : begin a dump, only looked at while idle
//   RDATA  : register bank read data, combinational from RADDR
//   RADDR  : register bank read address (registered)
//   TXD    : serial output, idles high
//   BUSY   : high while a dump is in progress
//   DONE   : one-cycle pulse after the final stop bit
// ============================================================================
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int NREG     = 8,
  parameter int AW       = 3,
  parameter int BAUD_DIV = 16
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic          START,
  input  logic [7:0]    RDATA,
  output logic [AW-1:0] RADDR,
  output logic          TXD,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  state_e        state_q;
  logic [AW-1:0] raddr_q;
  logic          txd_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;

  logic          baud_clr;
  logic          tick;

  // Restart the bit timer as the frame is loaded, so the start bit gets a
  // full BAUD_DIV cycles measured from the edge that drives TXD low.
  assign baud_clr = (state_q == LOAD);

  baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_i   (CLK),
    .rst_ni  (CLR_N),
    .clear_i (baud_clr),
    .tick_o  (tick)
  );

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= IDLE;
      raddr_q  <= '0;
      txd_q    <= TXD_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= TXD_IDLE;
          if (START) begin
            state_q <= ADDR;
            raddr_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Spend one cycle with the new address on the bank so RDATA is
        // stable before it is captured.
        ADDR: begin
          state_q <= LOAD;
        end

        // Snapshot the register; later writes cannot disturb this frame.
        LOAD: begin
          shift_q <= RDATA;
          txd_q   <= 1'b0;
          state_q <= START_BIT;
        end

        START_BIT: begin
          if (tick) begin
            txd_q    <= shift_q[0];
            bitcnt_q <= '0;
            state_q  <= DATA;
          end
        end

        // TXD always carries shift_q[0]; the next bit to present is
        // therefore shift_q[1] just before the right shift.
        DATA: begin
          if (tick) begin
            if (bitcnt_q == LAST_BIT) begin
              txd_q   <= TXD_IDLE;
              state_q <= STOP_BIT;
            end else begin
              txd_q    <= shift_q[1];
              shift_q  <= {1'b0, shift_q[7:1]};
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end

        STOP_BIT: begin
          if (tick) begin
            if (raddr_q == LAST_ADDR) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              raddr_q <= '0;
            end else begin
              raddr_q <= raddr_q + 1'b1;
              state_q <= ADDR;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= TXD_IDLE;
          busy_q  <= 1'b0;
          raddr_q <= '0;
        end
      endcase
    end
  end

  assign RADDR = raddr_q;
  assign TXD   = txd_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule : reg_dump_tx
`default_nettype wire
